// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared state encodings, stage ids and defaults for the layer sequencer
//
// Purpose: common definitions for the CNN layer sequencer and its watchdog.
// Ports:   none (package).

package layer_sequencer_pkg;

    // Sequencer state encoding (3 bits).
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FINISH  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    // Stage identifiers in launch order.
    typedef enum logic [1:0] {
        STG_IMG_IN = 2'd0,
        STG_CONV   = 2'd1,
        STG_POOL   = 2'd2,
        STG_FC     = 2'd3
    } stage_id_t;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_IDX_W      = 2;
    localparam int DEF_TIMEOUT    = 4095;
    localparam int DEF_CNT_W      = 12;

    // True for states in which a pass is in progress.
    function automatic logic is_busy(input state_t s);
        return (s != S_IDLE) && (s != S_ERROR);
    endfunction

endpackage

// File: rtl/layer_sequencer_stage_watchdog.sv
// rtl/layer_sequencer_stage_watchdog.sv - saturating per-stage watchdog counter
//
// Purpose: counts WAIT cycles of the current stage and flags the cycle whose
//          increment brings the count to TIMEOUT.
// Ports:
//   clk      in   1   clock
//   rst      in   1   synchronous reset, active-low
//   clr      in   1   clear count to 0
//   en       in   1   count this cycle
//   expired  out  1   this enabled cycle makes the count reach TIMEOUT

module layer_sequencer_stage_watchdog
    import layer_sequencer_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Flagged one cycle early so the FSM can let a done in that same cycle win
    // over the timeout without an extra registered stage.
    assign expired = en && (count >= LIMIT_M1);

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - sequences CNN datapath stages with watchdog and abort
//
// Purpose: on net_start, launches each stage in order with a 1-cycle start
//          pulse, waits for its done, and reports completion or a hung stage.
// Ports:
//   clk          in   1           clock
//   rst          in   1           synchronous reset, active-low
//   net_start    in   1           request a full pass (sampled in IDLE)
//   abort        in   1           cancel the pass / clear error
//   stage_done   in   NUM_STAGES  per-stage completion
//   stage_start  out  NUM_STAGES  one-hot launch pulse
//   stage_idx    out  IDX_W       stage being run, 0 in IDLE
//   net_busy     out  1           pass in progress
//   net_done     out  1           1-cycle completion pulse
//   timeout_err  out  1           held while in ERROR

module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  net_start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  net_busy,
    output logic                  net_done,
    output logic                  timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t                  state;
    state_t                  nxt_state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        nxt_idx;
    logic [NUM_STAGES-1:0]   launch_vec;
    logic                    done_cur;
    logic                    wd_clr;
    logic                    wd_en;
    logic                    expired;

    // Only the running stage's done is ever looked at.
    assign done_cur = stage_done[idx];

    assign wd_clr = (state != S_WAIT);
    assign wd_en  = (state == S_WAIT) && !done_cur;

    layer_sequencer_stage_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (expired)
    );

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            S_IDLE: begin
                // abort wins over net_start here
                if (net_start && !abort) begin
                    nxt_state = S_LAUNCH;
                    nxt_idx   = '0;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    nxt_state = S_IDLE;
                    nxt_idx   = '0;
                end else begin
                    nxt_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // Priority: abort, then done, then timeout.
                if (abort) begin
                    nxt_state = S_IDLE;
                    nxt_idx   = '0;
                end else if (done_cur) begin
                    nxt_state = (idx == LAST_IDX) ? S_FINISH : S_ADVANCE;
                end else if (expired) begin
                    nxt_state = S_ERROR;
                end
            end
            S_ADVANCE: begin
                if (abort) begin
                    nxt_state = S_IDLE;
                    nxt_idx   = '0;
                end else begin
                    nxt_state = S_LAUNCH;
                    nxt_idx   = idx + 1'b1;
                end
            end
            S_FINISH: begin
                nxt_state = S_IDLE;
                nxt_idx   = '0;
            end
            S_ERROR: begin
                // idx stays frozen to name the hung stage
                if (abort) begin
                    nxt_state = S_IDLE;
                    nxt_idx   = '0;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_idx   = '0;
            end
        endcase
    end

    always_comb begin
        launch_vec          = '0;
        launch_vec[nxt_idx] = 1'b1;
    end

    // Outputs are registered from the next state/index so they line up with
    // the state register each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            stage_start <= '0;
            stage_idx   <= '0;
            net_busy    <= 1'b0;
            net_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            stage_start <= (nxt_state == S_LAUNCH) ? launch_vec : '0;
            stage_idx   <= nxt_idx;
            net_busy    <= is_busy(nxt_state);
            net_done    <= (nxt_state == S_FINISH);
            timeout_err <= (nxt_state == S_ERROR);
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - table-driven scoreboard bench for layer_sequencer

module tb_layer_sequencer;

    localparam int NS = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          net_start = 1'b0;
    logic          abort = 1'b0;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_start;
    logic [1:0]    stage_idx;
    logic          net_busy;
    logic          net_done;
    logic          timeout_err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_STAGES (NS),
        .IDX_W      (2),
        .TIMEOUT    (TO),
        .CNT_W      (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .net_start   (net_start),
        .abort       (abort),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .stage_idx   (stage_idx),
        .net_busy    (net_busy),
        .net_done    (net_done),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [3:0] start;
        logic [1:0] idx;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    // Delays are cycles from a stage's start pulse to its done pulse; a delay
    // above TO means the stage never answers. Cycle -1 disables an event.
    typedef struct {
        string name;
        int d0, d1, d2, d3;
        int stray_stg, stray_cyc;
        int abort_cyc, rst_cyc, start2_cyc;
        int ncyc;
    } rec_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    rec_t tbl[12];

    // Launch schedule: stage 0 starts in cycle 1, each next start comes
    // delay+2 cycles later; returns index of the hung stage or -1.
    function automatic int schedule(input rec_t r, output int st[4], output int d[4]);
        int s;
        int hung;
        d = '{r.d0, r.d1, r.d2, r.d3};
        st = '{0, 0, 0, 0};
        s = 1;
        hung = -1;
        for (int i = 0; i < 4; i++) begin
            if (hung < 0) begin
                st[i] = s;
                if (d[i] > TO) hung = i;
                else s = s + d[i] + 2;
            end
        end
        return hung;
    endfunction

    function automatic exp_t expect_at(input rec_t r, input int c);
        exp_t e;
        int   st[4];
        int   d[4];
        int   hung, errc, fin, kill, hi;
        e = '0;
        kill = 1 << 30;
        if (r.abort_cyc >= 0) kill = r.abort_cyc;
        if (r.rst_cyc >= 0 && r.rst_cyc < kill) kill = r.rst_cyc;
        if (c > kill) return e;
        hung = schedule(r, st, d);
        errc = (hung >= 0) ? st[hung] + TO + 1 : 0;
        fin  = (hung < 0) ? st[3] + d[3] + 1 : -1;
        if (hung >= 0 && c >= errc) begin
            e.idx = 2'(hung);
            e.err = 1'b1;
            return e;
        end
        for (int i = 0; i < 4; i++) begin
            if (hung < 0 || i <= hung) begin
                hi = (i == hung) ? errc - 1 : st[i] + d[i] + 1;
                if (c == st[i]) e.start = 4'(1 << i);
                if (c >= st[i] && c <= hi) begin
                    e.idx  = 2'(i);
                    e.busy = 1'b1;
                end
            end
        end
        if (c == fin) e.done = 1'b1;
        return e;
    endfunction

    function automatic logic [3:0] done_at(input rec_t r, input int c);
        logic [3:0] v;
        int st[4];
        int d[4];
        int hung;
        v = '0;
        hung = schedule(r, st, d);
        for (int i = 0; i < 4; i++) begin
            if ((hung < 0 || i < hung) && c == st[i] + d[i]) v[i] = 1'b1;
        end
        if (r.stray_stg >= 0 && c == r.stray_cyc) v[r.stray_stg] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int c);
        exp_t got;
        exp_t want;
        got  = {stage_start, stage_idx, net_busy, net_done, timeout_err};
        want = q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got start=%b idx=%0d busy=%b done=%b err=%b, expected start=%b idx=%0d busy=%b done=%b err=%b",
                     name, c, got.start, got.idx, got.busy, got.done, got.err,
                     want.start, want.idx, want.busy, want.done, want.err);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; net_start = 1'b0; abort = 1'b0; stage_done = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        q.push_back('0);
        @(negedge clk);
        check("reset", 0);
    endtask

    task automatic run(input rec_t r);
        for (int c = 0; c < r.ncyc; c++) begin
            @(posedge clk); #1;
            net_start  = (c == 0) || (c == r.start2_cyc);
            abort      = (c == r.abort_cyc);
            rst        = !(c == r.rst_cyc);
            stage_done = done_at(r, c);
            q.push_back(expect_at(r, c));
            @(negedge clk);
            check(r.name, c);
        end
        @(posedge clk); #1;
        net_start = 1'b0; abort = 1'b0; rst = 1'b1; stage_done = '0;
    endtask

    initial begin
        tbl[0]  = '{"nominal",      5, 5, 5, 5,  -1, -1, -1, -1, -1, 32};
        tbl[1]  = '{"stray_done",   5, 5, 5, 5,   2,  3, -1, -1, -1, 32};
        tbl[2]  = '{"launch_done",  5, 5, 5, 5,   1,  8, -1, -1, -1, 32};
        tbl[3]  = '{"timeout",      5, 99, 5, 5, -1, -1, 20, -1, 17, 24};
        tbl[4]  = '{"abort_wait",   5, 5, 5, 5,  -1, -1, 20, -1, -1, 26};
        tbl[5]  = '{"deadline",     3, 8, 1, 2,  -1, -1, -1, -1, -1, 26};
        tbl[6]  = '{"reset_mid",    5, 5, 5, 5,  -1, -1, -1, 10, -1, 14};
        tbl[7]  = '{"restart",      2, 3, 4, 1,  -1, -1, -1, -1, -1, 22};
        tbl[8]  = '{"finish_start", 1, 1, 1, 1,  -1, -1, -1, -1, 12, 16};
        tbl[9]  = '{"abort_idle",   5, 5, 5, 5,  -1, -1,  0, -1, -1,  4};
        tbl[10] = '{"abort_adv",    5, 5, 5, 5,  -1, -1,  7, -1, -1, 12};
        tbl[11] = '{"last_timeout", 1, 1, 1, 99,  0, 20, 22, -1, -1, 25};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run(tbl[i]);
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
